// File: rtl/rv_uart_pkg.sv
// Shared types and helpers for the UART program loader.
// The receive FSM state type, the baud divisor helper and the word-write byte enable.
package rv_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_state_t;

  localparam logic [3:0] MEM_WORD_EN = 4'hF;

  function automatic int baud_div(int clk_hz, int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF input synchroniser, bit timer and receive FSM.
// byte_vld and frame_err_p pulse combinationally in the cycle the stop bit is sampled.
module uart_rx_byte
  import rv_uart_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_vld,
  output logic [7:0] byte_dat,
  output logic       frame_err_p,
  output logic       busy
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(DIV - 1);

  uart_state_t      state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             rx_s;
  logic             timer_zero;

  assign rx_s       = sync_q[1];
  assign timer_zero = (timer_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sync_q    <= 2'b11;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], rx};
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_vld    = 1'b0;
    frame_err_p = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          timer_d = HALF_LOAD;
          state_d = START;
        end
      end
      START: begin
        if (!timer_zero) begin
          timer_d = timer_q - CNT_W'(1);
        end else if (rx_s) begin
          state_d = IDLE;
        end else begin
          timer_d   = FULL_LOAD;
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (!timer_zero) begin
          timer_d = timer_q - CNT_W'(1);
        end else begin
          shift_d   = {rx_s, shift_q[7:1]};
          timer_d   = FULL_LOAD;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (!timer_zero) begin
          timer_d = timer_q - CNT_W'(1);
        end else if (rx_s) begin
          byte_vld = 1'b1;
          state_d  = IDLE;
        end else begin
          frame_err_p = 1'b1;
          state_d     = WAIT_IDLE;
        end
      end
      // A held-low line (break) must return high before another start is accepted.
      WAIT_IDLE: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_dat = shift_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: packs received bytes into little-endian words and issues
// one single-cycle memory write per completed word while prog is high.
module uart_prog_loader
  import rv_uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        rx,
  input  logic        prog,
  output logic        mem_wea,
  output logic [3:0]  mem_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [15:0] word_count,
  output logic        frame_err,
  output logic        busy
);

  localparam int DIV = baud_div(CLK_HZ, BAUD);

  logic       byte_vld;
  logic [7:0] byte_dat;
  logic       frame_err_p;

  uart_rx_byte #(
    .DIV(DIV)
  ) u_rx (
    .clk        (clk),
    .rst_n      (Rst),
    .rx         (rx),
    .byte_vld   (byte_vld),
    .byte_dat   (byte_dat),
    .frame_err_p(frame_err_p),
    .busy       (busy)
  );

  logic        prog_q, prog_d;
  logic [31:0] addr_ptr_q, addr_ptr_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] word_q, word_d;
  logic        mem_wea_q, mem_wea_d;
  logic [3:0]  mem_en_q, mem_en_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_din_q, mem_din_d;
  logic [15:0] word_count_q, word_count_d;
  logic        frame_err_q, frame_err_d;
  logic        prog_rise;

  assign prog_rise = prog & ~prog_q;

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      prog_q       <= 1'b0;
      addr_ptr_q   <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      mem_wea_q    <= 1'b0;
      mem_en_q     <= '0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      word_count_q <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      prog_q       <= prog_d;
      addr_ptr_q   <= addr_ptr_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      mem_wea_q    <= mem_wea_d;
      mem_en_q     <= mem_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      word_count_q <= word_count_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // The prog-rise clear is applied first so a coincident byte lands as byte 0 at address 0.
  always_comb begin
    prog_d       = prog;
    addr_ptr_d   = addr_ptr_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    mem_wea_d    = 1'b0;
    mem_en_d     = 4'h0;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    word_count_d = word_count_q;
    frame_err_d  = frame_err_q;

    if (prog_rise) begin
      addr_ptr_d   = '0;
      byte_idx_d   = '0;
      word_count_d = '0;
      frame_err_d  = 1'b0;
    end

    if (!prog) begin
      byte_idx_d = '0;
    end else if (byte_vld) begin
      case (byte_idx_d)
        2'd0: word_d[7:0]   = byte_dat;
        2'd1: word_d[15:8]  = byte_dat;
        2'd2: word_d[23:16] = byte_dat;
        default: begin
          mem_wea_d  = 1'b1;
          mem_en_d   = MEM_WORD_EN;
          mem_addr_d = addr_ptr_d;
          mem_din_d  = {byte_dat, word_q};
          addr_ptr_d = addr_ptr_d + 32'd4;
          if (word_count_d != 16'hFFFF) begin
            word_count_d = word_count_d + 16'd1;
          end
        end
      endcase
      byte_idx_d = byte_idx_d + 2'd1;
    end

    if (frame_err_p) begin
      frame_err_d = 1'b1;
    end
  end

  assign mem_wea    = mem_wea_q;
  assign mem_en     = mem_en_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign word_count = word_count_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed self-checking bench for uart_prog_loader at 10 clocks per UART bit.
module tb_uart_prog_loader;

  logic        clk = 1'b0;
  logic        rstN;
  logic        rx;
  logic        prog;
  logic        memWea;
  logic [3:0]  memEn;
  logic [31:0] memAddr;
  logic [31:0] memDin;
  logic [15:0] wordCount;
  logic        frameErr;
  logic        busy;

  int checkCount = 0;
  int passCount  = 0;
  int base;

  logic [31:0] wrAddr[$];
  logic [31:0] wrDin[$];
  logic [3:0]  wrEn[$];

  uart_prog_loader #(
    .CLK_HZ(1_000_000),
    .BAUD  (100_000)
  ) dut (
    .clk       (clk),
    .Rst       (rstN),
    .rx        (rx),
    .prog      (prog),
    .mem_wea   (memWea),
    .mem_en    (memEn),
    .mem_addr  (memAddr),
    .mem_din   (memDin),
    .word_count(wordCount),
    .frame_err (frameErr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Every write pulse is logged so tests can compare against expected writes.
  always @(negedge clk) begin
    if (memWea === 1'b1) begin
      wrAddr.push_back(memAddr);
      wrDin.push_back(memDin);
      wrEn.push_back(memEn);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (10) @(negedge clk);
    end
    rx = stopBit;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(w[8*i +: 8], 1'b1);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic checkWrite(input int idx, input logic [31:0] expAddr, input logic [31:0] expDin);
    if (idx < wrAddr.size()) begin
      checkOutput("wr_addr", wrAddr[idx], expAddr);
      checkOutput("wr_din", wrDin[idx], expDin);
      checkOutput("wr_en", 32'(wrEn[idx]), 32'hF);
    end else begin
      checkOutput("wr_missing", 32'(wrAddr.size()), 32'(idx + 1));
    end
  endtask

  task automatic restartProg();
    prog = 1'b0;
    repeat (2) @(negedge clk);
    prog = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wea"}, 32'(memWea), 32'h0);
    checkOutput({tag, "_en"}, 32'(memEn), 32'h0);
    checkOutput({tag, "_addr"}, memAddr, 32'h0);
    checkOutput({tag, "_din"}, memDin, 32'h0);
    checkOutput({tag, "_wcount"}, 32'(wordCount), 32'h0);
    checkOutput({tag, "_ferr"}, 32'(frameErr), 32'h0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    rstN = 1'b0;
    rx   = 1'b1;
    prog = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rstN = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] two words back to back");
    prog = 1'b1;
    repeat (2) @(negedge clk);
    sendWord(32'h12345678);
    sendWord(32'hDEADBEEF);
    checkOutput("t1_count", 32'(wrAddr.size()), 32'd2);
    checkWrite(0, 32'h0, 32'h12345678);
    checkWrite(1, 32'h4, 32'hDEADBEEF);
    checkOutput("t1_wcount", 32'(wordCount), 32'd2);
    checkOutput("t1_addr_hold", memAddr, 32'h4);
    checkOutput("t1_din_hold", memDin, 32'hDEADBEEF);
    checkOutput("t1_wea_idle", 32'(memWea), 32'h0);
    checkOutput("t1_en_idle", 32'(memEn), 32'h0);

    $display("[TB] start-bit glitch");
    base = wrAddr.size();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t2_busy_hi", 32'(busy), 32'h1);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("t2_busy_lo", 32'(busy), 32'h0);
    checkOutput("t2_count", 32'(wrAddr.size()), 32'(base));
    checkOutput("t2_wcount", 32'(wordCount), 32'd2);

    $display("[TB] framing error then a good word");
    restartProg();
    base = wrAddr.size();
    applyStimulus(8'h55, 1'b0);
    checkOutput("t3_ferr_set", 32'(frameErr), 32'h1);
    sendWord(32'h44332211);
    checkOutput("t3_ferr_sticky", 32'(frameErr), 32'h1);
    checkOutput("t3_count", 32'(wrAddr.size()), 32'(base + 1));
    checkWrite(base, 32'h0, 32'h44332211);
    checkOutput("t3_wcount", 32'(wordCount), 32'd1);

    $display("[TB] bytes discarded while prog low");
    prog = 1'b0;
    repeat (2) @(negedge clk);
    base = wrAddr.size();
    sendWord(32'hCAFEF00D);
    checkOutput("t4_no_write", 32'(wrAddr.size()), 32'(base));
    checkOutput("t4_ferr_kept", 32'(frameErr), 32'h1);
    prog = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("t4_ferr_clr", 32'(frameErr), 32'h0);
    checkOutput("t4_wcount_clr", 32'(wordCount), 32'h0);
    sendWord(32'h04030201);
    checkOutput("t4_count", 32'(wrAddr.size()), 32'(base + 1));
    checkWrite(base, 32'h0, 32'h04030201);

    $display("[TB] partial word lost on prog drop");
    restartProg();
    base = wrAddr.size();
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'h02, 1'b1);
    restartProg();
    sendWord(32'hDDCCBBAA);
    checkOutput("t5_count", 32'(wrAddr.size()), 32'(base + 1));
    checkWrite(base, 32'h0, 32'hDDCCBBAA);
    checkOutput("t5_wcount", 32'(wordCount), 32'd1);

    $display("[TB] reset mid-byte");
    base = wrAddr.size();
    applyStimulus(8'h10, 1'b1);
    applyStimulus(8'h20, 1'b1);
    applyStimulus(8'h30, 1'b1);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      repeat (10) @(negedge clk);
    end
    checkOutput("t6_busy_pre", 32'(busy), 32'h1);
    rstN = 1'b0;
    #1;
    checkAllZero("t6_rst");
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("t6_no_write", 32'(wrAddr.size()), 32'(base));
    sendWord(32'hF0DEBC9A);
    checkOutput("t6_count", 32'(wrAddr.size()), 32'(base + 1));
    checkWrite(base, 32'h0, 32'hF0DEBC9A);
    checkOutput("t6_wcount", 32'(wordCount), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
